// File: rtl/iir_sos_ctrl.sv
// Controller for one clock-gated biquad section: two gated MAC edges per sample plus coefficient
// loads. Define IIR_SOS_CTRL_SHADOW_EN for double-buffered (shadow + commit) coefficient updates.
module iir_sos_ctrl #(
  parameter int unsigned COEFF_W = 17,
  parameter int unsigned SAMP_W  = 25
) (
  input  logic               c_clk,
  input  logic               nrst,
  input  logic               in_valid,
  input  logic [SAMP_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [COEFF_W-1:0] cfg_data,
  input  logic               cfg_commit,
  output logic               ce,
  output logic               mult_sel,
  output logic               c_we,
  output logic [1:0]         c_addr,
  output logic [COEFF_W-1:0] c_in,
  output logic [SAMP_W-1:0]  din,
  input  logic [SAMP_W-1:0]  sec_dout,
  output logic               out_valid,
  output logic [SAMP_W-1:0]  out_data,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle,
    StMac0,
    StMac1,
    StLatch
`ifdef IIR_SOS_CTRL_SHADOW_EN
    ,
    StLoad0,
    StLoad1,
    StLoad2
`endif
  } state_e;

  state_e               state_q, state_d;
  logic                 accept;
  logic                 we_pre;
  logic                 ce_q, mult_sel_q, c_we_q;
  logic [1:0]           c_addr_q;
  logic [COEFF_W-1:0]   c_in_q;
  logic [SAMP_W-1:0]    din_q, out_data_q;
  logic                 out_valid_q;

`ifdef IIR_SOS_CTRL_SHADOW_EN
  logic               pend_q, pend_d;
  logic [COEFF_W-1:0] a0_q, a1_q, b_q;
  logic [COEFF_W-1:0] a0_d, a1_d, b_d;

  always_comb begin
    a0_d = a0_q;
    a1_d = a1_q;
    b_d  = b_q;
    if (cfg_wr) begin
      case (cfg_addr)
        2'd0:    a0_d = cfg_data;
        2'd1:    a1_d = cfg_data;
        2'd2:    b_d  = cfg_data;
        default: ;
      endcase
    end
  end

  // Pending is consumed on entry to LOAD0, so a commit during a load pass re-arms another pass.
  always_comb begin
    pend_d = pend_q;
    if ((state_q == StIdle) && pend_q) pend_d = 1'b0;
    if (cfg_commit) pend_d = 1'b1;
  end

  assign in_ready = (state_q == StIdle) && !pend_q;
  assign we_pre   = (state_q == StLoad0) || (state_q == StLoad1) || (state_q == StLoad2);
  assign busy     = (state_q != StIdle) || pend_q;

  // c_addr/c_in follow the next state and the next shadow value, so late host writes are sent.
  always_ff @(posedge c_clk or negedge nrst) begin
    if (!nrst) begin
      pend_q   <= 1'b0;
      a0_q     <= '0;
      a1_q     <= '0;
      b_q      <= '0;
      c_addr_q <= '0;
      c_in_q   <= '0;
    end else begin
      pend_q <= pend_d;
      a0_q   <= a0_d;
      a1_q   <= a1_d;
      b_q    <= b_d;
      case (state_d)
        StLoad0: begin c_addr_q <= 2'd0; c_in_q <= a0_d; end
        StLoad1: begin c_addr_q <= 2'd1; c_in_q <= a1_d; end
        StLoad2: begin c_addr_q <= 2'd2; c_in_q <= b_d;  end
        default: ;
      endcase
    end
  end
`else
  logic wr_go, wr_q, unused_commit;

  assign unused_commit = cfg_commit;
  assign wr_go    = cfg_wr && (state_q == StIdle) && (cfg_addr != 2'd3);
  assign in_ready = (state_q == StIdle) && !wr_q && !wr_go;
  assign we_pre   = wr_q;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge c_clk or negedge nrst) begin
    if (!nrst) begin
      wr_q     <= 1'b0;
      c_addr_q <= '0;
      c_in_q   <= '0;
    end else begin
      wr_q <= wr_go;
      if (wr_go) begin
        c_addr_q <= cfg_addr;
        c_in_q   <= cfg_data;
      end
    end
  end
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
`ifdef IIR_SOS_CTRL_SHADOW_EN
        if (pend_q) state_d = StLoad0;
        else
`endif
        if (accept) state_d = StMac0;
      end
      StMac0:  state_d = StMac1;
      StMac1:  state_d = StLatch;
      StLatch: state_d = StIdle;
`ifdef IIR_SOS_CTRL_SHADOW_EN
      StLoad0: state_d = StLoad1;
      StLoad1: state_d = StLoad2;
      StLoad2: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge c_clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      din_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_q == StLatch);
      if (accept) din_q <= in_data;
      if (state_q == StLatch) out_data_q <= sec_dout;
    end
  end

  // Falling-edge retiming keeps clk & ce glitch-free: enables change only while clk is low.
  always_ff @(negedge c_clk or negedge nrst) begin
    if (!nrst) begin
      ce_q       <= 1'b0;
      mult_sel_q <= 1'b0;
      c_we_q     <= 1'b0;
    end else begin
      ce_q       <= (state_q == StMac0) || (state_q == StMac1);
      mult_sel_q <= (state_q == StMac1);
      c_we_q     <= we_pre;
    end
  end

  assign ce        = ce_q;
  assign mult_sel  = mult_sel_q;
  assign c_we      = c_we_q;
  assign c_addr    = c_addr_q;
  assign c_in      = c_in_q;
  assign din       = din_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
